// File: rtl/ysyx_23060286_lsu.sv
// ysyx_23060286_lsu: load/store unit that retires one instruction at a time into the register file
module ysyx_23060286_lsu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_is_load,
  input  logic        in_is_store,
  input  logic [2:0]  in_funct3,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  input  logic [4:0]  in_rd,
  input  logic        in_rd_wen,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic        mem_wen,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rdata,
  output logic        rf_wen,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        done,
  output logic        misalign_err
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, WB} state_t;
  state_t      state_q, state_d;
  logic        load_q, load_d;
  logic        store_q, store_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [4:0]  rd_q, rd_d;
  logic        rd_wen_q, rd_wen_d;
  logic        err_q, err_d;
  logic [31:0] result_q, result_d;
  logic        mem_op, illegal, misal, bad;
  logic [3:0]  lane_strb;
  logic [31:0] lane_data, shifted, ext;
  // Decode legality and store byte lanes of the incoming instruction
  always_comb begin
    mem_op    = in_is_load | in_is_store;
    illegal   = (in_funct3 == 3'd3) | (in_funct3[2:1] == 2'b11);
    misal     = ((in_funct3[1:0] == 2'b01) & in_addr[0]) | ((in_funct3[1:0] == 2'b10) & (in_addr[1:0] != 2'b00));
    bad       = mem_op & (illegal | misal);
    lane_strb = (in_funct3[1:0] == 2'b00) ? 4'b0001 << in_addr[1:0] :
                (in_funct3[1:0] == 2'b01) ? 4'b0011 << in_addr[1:0] : 4'b1111;
    lane_data = (in_funct3[1:0] == 2'b00) ? {4{in_wdata[7:0]}} :
                (in_funct3[1:0] == 2'b01) ? {2{in_wdata[15:0]}} : in_wdata;
  end
  // Extract and extend the addressed byte/halfword of the read word
  always_comb begin
    shifted = mem_rdata >> {off_q, 3'b000};
    ext     = (funct3_q == 3'd0) ? {{24{shifted[7]}}, shifted[7:0]} :
              (funct3_q == 3'd1) ? {{16{shifted[15]}}, shifted[15:0]} :
              (funct3_q == 3'd4) ? {24'd0, shifted[7:0]} :
              (funct3_q == 3'd5) ? {16'd0, shifted[15:0]} : mem_rdata;
  end
  // Next-state logic: latch on accept, hold request until taken, capture load data on response
  always_comb begin
    state_d  = state_q;
    load_d   = load_q;
    store_d  = store_q;
    funct3_d = funct3_q;
    off_d    = off_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    rd_d     = rd_q;
    rd_wen_d = rd_wen_q;
    err_d    = err_q;
    result_d = result_q;
    case (state_q)
      IDLE: if (in_valid) begin
        load_d   = in_is_load;
        store_d  = in_is_store;
        funct3_d = in_funct3;
        off_d    = in_addr[1:0];
        addr_d   = {in_addr[31:2], 2'b00};
        wdata_d  = lane_data;
        wstrb_d  = in_is_store ? lane_strb : 4'b0000;
        rd_d     = in_rd;
        rd_wen_d = in_rd_wen;
        err_d    = bad;
        result_d = in_addr;
        state_d  = (mem_op & ~bad) ? REQ : WB;
      end
      REQ:  state_d = mem_req_ready ? WAIT : REQ;
      WAIT: if (mem_rsp_valid) begin
        result_d = load_q ? ext : result_q;
        state_d  = WB;
      end
      default: state_d = IDLE;
    endcase
  end
  // State and latched-field registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      load_q   <= 1'b0;
      store_q  <= 1'b0;
      funct3_q <= 3'd0;
      off_q    <= 2'd0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      wstrb_q  <= 4'd0;
      rd_q     <= 5'd0;
      rd_wen_q <= 1'b0;
      err_q    <= 1'b0;
      result_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      load_q   <= load_d;
      store_q  <= store_d;
      funct3_q <= funct3_d;
      off_q    <= off_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      rd_q     <= rd_d;
      rd_wen_q <= rd_wen_d;
      err_q    <= err_d;
      result_q <= result_d;
    end
  end
  assign in_ready      = state_q == IDLE;
  assign mem_req_valid = state_q == REQ;
  assign mem_addr      = addr_q;
  assign mem_wen       = store_q;
  assign mem_wdata     = wdata_q;
  assign mem_wstrb     = wstrb_q;
  assign done          = state_q == WB;
  assign misalign_err  = done & err_q;
  assign rf_wen        = done & rd_wen_q & (rd_q != 5'd0) & ~store_q & ~err_q;
  assign rf_waddr      = rd_q;
  assign rf_wdata      = result_q;
endmodule

// File: tb/tb_ysyx_23060286_lsu.sv
// tb_ysyx_23060286_lsu: directed self-checking bench for the load/store unit
module tb_ysyx_23060286_lsu;
  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, in_is_load, in_is_store, in_rd_wen;
  logic [2:0]  in_funct3;
  logic [31:0] in_addr, in_wdata;
  logic [4:0]  in_rd;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        rf_wen, done, misalign_err;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  int checks = 0;
  int failures = 0;
  ysyx_23060286_lsu dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_is_load(in_is_load), .in_is_store(in_is_store), .in_funct3(in_funct3),
    .in_addr(in_addr), .in_wdata(in_wdata), .in_rd(in_rd), .in_rd_wen(in_rd_wen),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .done(done), .misalign_err(misalign_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic ld, input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [4:0] rd, input logic rdw);
    in_valid = 1'b1; in_is_load = ld; in_is_store = st; in_funct3 = f3;
    in_addr = a; in_wdata = wd; in_rd = rd; in_rd_wen = rdw;
    tick();
    in_valid = 1'b0;
  endtask
  task automatic load_seq(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] rdata, input logic [4:0] rd, input logic [31:0] exp);
    issue(1'b1, 1'b0, f3, a, 32'h0, rd, 1'b1);
    chk({tag, "_req_valid"}, mem_req_valid, 1'b1);
    chk({tag, "_addr"}, mem_addr, {a[31:2], 2'b00});
    chk({tag, "_wstrb"}, mem_wstrb, 4'b0000);
    chk({tag, "_wen"}, mem_wen, 1'b0);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rdata = rdata;
    chk({tag, "_wait_noreq"}, mem_req_valid, 1'b0);
    tick();
    mem_rsp_valid = 1'b0;
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_rf_wen"}, rf_wen, 1'b1);
    chk({tag, "_rf_waddr"}, rf_waddr, rd);
    chk({tag, "_rf_wdata"}, rf_wdata, exp);
    tick();
    chk({tag, "_idle"}, in_ready, 1'b1);
  endtask
  task automatic store_seq(input string tag, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input logic [3:0] strb, input logic [31:0] data);
    issue(1'b0, 1'b1, f3, a, wd, 5'd3, 1'b1);
    chk({tag, "_req_valid"}, mem_req_valid, 1'b1);
    chk({tag, "_addr"}, mem_addr, {a[31:2], 2'b00});
    chk({tag, "_wstrb"}, mem_wstrb, strb);
    chk({tag, "_wdata"}, mem_wdata, data);
    chk({tag, "_wen"}, mem_wen, 1'b1);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b1;
    tick();
    mem_rsp_valid = 1'b0;
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_rf_wen"}, rf_wen, 1'b0);
    tick();
  endtask
  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_is_load = 1'b0; in_is_store = 1'b0; in_funct3 = 3'd0;
    in_addr = 32'h0; in_wdata = 32'h0; in_rd = 5'd0; in_rd_wen = 1'b0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = 32'h0;
    #3;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_req_valid", mem_req_valid, 1'b0);
    chk("rst_wen", mem_wen, 1'b0);
    chk("rst_wstrb", mem_wstrb, 4'b0000);
    chk("rst_rf_wen", rf_wen, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", misalign_err, 1'b0);
    chk("rst_waddr", rf_waddr, 5'd0);
    chk("rst_wdata", rf_wdata, 32'h0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_mwdata", mem_wdata, 32'h0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    issue(1'b0, 1'b0, 3'd0, 32'h1234_5678, 32'h0, 5'd5, 1'b1);
    chk("alu_rf_wen", rf_wen, 1'b1);
    chk("alu_waddr", rf_waddr, 5'd5);
    chk("alu_wdata", rf_wdata, 32'h1234_5678);
    chk("alu_done", done, 1'b1);
    chk("alu_err", misalign_err, 1'b0);
    chk("alu_busy", in_ready, 1'b0);
    chk("alu_noreq", mem_req_valid, 1'b0);
    tick();
    chk("alu_ready_again", in_ready, 1'b1);
    chk("alu_done_drop", done, 1'b0);
    chk("alu_rf_wen_drop", rf_wen, 1'b0);
    issue(1'b0, 1'b0, 3'd0, 32'hCAFE_0001, 32'h0, 5'd0, 1'b1);
    chk("rd0_rf_wen", rf_wen, 1'b0);
    chk("rd0_done", done, 1'b1);
    tick();
    load_seq("lb",  3'd0, 32'h8000_0003, 32'h80FF_FF7F, 5'd7, 32'hFFFF_FF80);
    load_seq("lbu", 3'd4, 32'h8000_0003, 32'h80FF_FF7F, 5'd8, 32'h0000_0080);
    load_seq("lh",  3'd1, 32'h8000_0002, 32'h80FF_FF7F, 5'd9, 32'hFFFF_80FF);
    load_seq("lhu", 3'd5, 32'h8000_0002, 32'h80FF_FF7F, 5'd10, 32'h0000_80FF);
    load_seq("lb0", 3'd0, 32'h8000_0000, 32'h80FF_FF7F, 5'd11, 32'h0000_007F);
    store_seq("sb", 3'd0, 32'h8000_0002, 32'hAABB_CCDD, 4'b0100, 32'hDDDD_DDDD);
    store_seq("sh", 3'd1, 32'h8000_0002, 32'hAABB_CCDD, 4'b1100, 32'hCCDD_CCDD);
    store_seq("sw", 3'd2, 32'h8000_0004, 32'hAABB_CCDD, 4'b1111, 32'hAABB_CCDD);
    issue(1'b1, 1'b0, 3'd2, 32'h8000_0004, 32'h0, 5'd12, 1'b1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_req_held", mem_req_valid, 1'b1);
      chk("bp_addr_stable", mem_addr, 32'h8000_0004);
      chk("bp_in_ready", in_ready, 1'b0);
      tick();
    end
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("bp_wait_noreq", mem_req_valid, 1'b0);
      chk("bp_wait_nodone", done, 1'b0);
      chk("bp_wait_in_ready", in_ready, 1'b0);
      tick();
    end
    mem_rsp_valid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    tick();
    mem_rsp_valid = 1'b0;
    chk("bp_done", done, 1'b1);
    chk("bp_rf_wen", rf_wen, 1'b1);
    chk("bp_wdata", rf_wdata, 32'hDEAD_BEEF);
    tick();
    chk("bp_idle", in_ready, 1'b1);
    issue(1'b1, 1'b0, 3'd2, 32'h8000_0002, 32'h0, 5'd13, 1'b1);
    chk("mis_noreq", mem_req_valid, 1'b0);
    chk("mis_done", done, 1'b1);
    chk("mis_err", misalign_err, 1'b1);
    chk("mis_rf_wen", rf_wen, 1'b0);
    tick();
    chk("mis_err_drop", misalign_err, 1'b0);
    issue(1'b1, 1'b0, 3'd3, 32'h8000_0000, 32'h0, 5'd14, 1'b1);
    chk("ill_noreq", mem_req_valid, 1'b0);
    chk("ill_done", done, 1'b1);
    chk("ill_err", misalign_err, 1'b1);
    chk("ill_rf_wen", rf_wen, 1'b0);
    tick();
    issue(1'b0, 1'b1, 3'd1, 32'h8000_0001, 32'h1111_2222, 5'd0, 1'b0);
    chk("sh_mis_noreq", mem_req_valid, 1'b0);
    chk("sh_mis_err", misalign_err, 1'b1);
    tick();
    issue(1'b1, 1'b0, 3'd2, 32'h8000_0000, 32'h0, 5'd15, 1'b1);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mrst_in_ready", in_ready, 1'b1);
    chk("mrst_req_valid", mem_req_valid, 1'b0);
    chk("mrst_done", done, 1'b0);
    chk("mrst_rf_wen", rf_wen, 1'b0);
    chk("mrst_wdata", rf_wdata, 32'h0);
    rst_n = 1'b1;
    mem_rsp_valid = 1'b1; mem_rdata = 32'h5555_AAAA;
    tick();
    mem_rsp_valid = 1'b0;
    chk("late_rsp_rf_wen", rf_wen, 1'b0);
    chk("late_rsp_done", done, 1'b0);
    chk("late_rsp_idle", in_ready, 1'b1);
    issue(1'b0, 1'b0, 3'd0, 32'h0BAD_F00D, 32'h0, 5'd4, 1'b1);
    chk("post_rst_rf_wen", rf_wen, 1'b1);
    chk("post_rst_waddr", rf_waddr, 5'd4);
    chk("post_rst_wdata", rf_wdata, 32'h0BAD_F00D);
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ysyx_23060286_lsu.md
# ysyx_23060286_lsu

Load/store and writeback-issue unit that sits directly upstream of the register file. It accepts one executed instruction at a time from the execute stage. It performs any memory access over a simple request/response bus and drives the register-file write port (write enable, write address, write data) for exactly one cycle per retiring instruction. Loads are sign- or zero-extended and stores are byte-lane aligned here, so the register file only ever sees final 32-bit values.

## Interface
Parameters: none (RV32, 32 registers, fixed).

Ports:
- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  execute stage presents an instruction
- in_ready  out  1  unit can accept; high only in IDLE
- in_is_load  in  1  instruction is a load
- in_is_store  in  1  instruction is a store; in_is_load and in_is_store are never both high
- in_funct3  in  3  access width/sign: 0=B, 1=H, 2=W, 4=BU, 5=HU
- in_addr  in  32  effective address (loads/stores) or ALU result (others)
- in_wdata  in  32  store data (rs2)
- in_rd  in  5  destination register
- in_rd_wen  in  1  instruction writes rd
- mem_req_valid  out  1  memory request valid
- mem_req_ready  in  1  memory accepts request
- mem_addr  out  32  word-aligned address, in_addr with bits [1:0] forced to 00
- mem_wen  out  1  1 = write, 0 = read
- mem_wdata  out  32  lane-shifted store data
- mem_wstrb  out  4  byte strobes; 0000 on reads
- mem_rsp_valid  in  1  read data valid or write acknowledge
- mem_rdata  in  32  raw word read data
- rf_wen  out  1  register-file write enable
- rf_waddr  out  5  register-file write address
- rf_wdata  out  32  register-file write data
- done  out  1  one-cycle retire pulse
- misalign_err  out  1  one-cycle pulse with done for misaligned or illegal access

## Operation
FSM states: IDLE, REQ, WAIT, WB.
- IDLE:
  - in_valid & in_ready latches all in_* fields.
  - Non-memory instruction: next state WB, result = in_addr.
  - Memory instruction, aligned and legal: next state REQ.
  - Misaligned or illegal: next state WB with error flag set.
  - Misaligned means H/HU with addr[0]=1, or W with addr[1:0]≠00. Illegal means funct3 3, 6 or 7 on a load/store.
- REQ:
  - mem_req_valid=1, with mem_addr/mem_wen/mem_wdata/mem_wstrb held stable.
  - On mem_req_ready, go to WAIT.
- WAIT:
  - On mem_rsp_valid, a load captures its extended result and goes to WB.
  - A store goes to WB on mem_rsp_valid (acknowledge).
  - mem_rsp_valid outside WAIT is ignored.
- WB:
  - done=1.
  - rf_wen=1 only if the latched rd_wen=1, rd≠0, not a store and no error.
  - rf_waddr = latched rd; rf_wdata = result.
  - misalign_err = error flag.
  - Always returns to IDLE next cycle.

Store lane rules (off = addr[1:0]):
- SB: wstrb = 0001<<off, wdata = {4{wdata[7:0]}}
- SH: wstrb = 0011<<off, wdata = {2{wdata[15:0]}}
- SW: wstrb = 1111, wdata unchanged

Load extraction:
- Byte = mem_rdata[8*off+7 : 8*off]; halfword = mem_rdata[8*off+15 : 8*off].
- B/H sign-extend to 32 bits; BU/HU zero-extend; W passes through.

## Timing
- Reset (asynchronous on rst_n low):
  - State goes to IDLE.
  - mem_req_valid, mem_wen, mem_wstrb, rf_wen, done, misalign_err go to 0.
  - rf_waddr goes to 0, rf_wdata to 0, mem_addr/mem_wdata to 0.
  - in_ready reads 1.
- Non-memory instruction: accepted at cycle N; rf_wen/done at N+1; in_ready high again at N+2.
- Load/store with zero-wait memory (ready same cycle as valid, rsp the next cycle):
  - accept N, REQ N+1, WAIT N+2, WB N+3.
  - Total latency = 3 + request stalls + response stalls.
- mem_req_valid never drops before mem_req_ready; request fields are stable while valid.
- Misaligned/illegal: WB at N+1, no bus activity at all.
- Throughput: at most one instruction in flight; in_ready=0 in REQ, WAIT and WB.
- Reset mid-transaction abandons the access. A response arriving after reset is ignored because the FSM is in IDLE.
- rf_wen is asserted for exactly one cycle per retiring instruction, never for rd=0.

## Test plan
- Non-memory: in_addr=0x1234_5678, rd=5, rd_wen=1 -> next cycle rf_wen=1, rf_waddr=5, rf_wdata=0x1234_5678, done=1; rd=0 case gives rf_wen=0, done=1.
- LB at addr 0x8000_0003, mem_rdata=0x80FF_FF7F -> mem_addr=0x8000_0000, mem_wstrb=0000, rf_wdata=0xFFFF_FF80. LBU at the same address -> 0x0000_0080. LH at offset 2 -> 0xFFFF_80FF.
- SB at addr 0x8000_0002, wdata=0xAABB_CCDD -> mem_wstrb=0100, mem_wdata=0xDDDD_DDDD, mem_wen=1, rf_wen=0 in WB. SH at offset 2 -> strobe 1100, data 0xCCDD_CCDD.
- Backpressure: hold mem_req_ready=0 for 5 cycles, then delay rsp 3 cycles -> mem_req_valid held with stable fields throughout, in_ready=0, WB exactly 1 cycle after rsp.
- LW at addr 0x8000_0002 and funct3=3 load -> no mem_req_valid, done=1 and misalign_err=1 one cycle after accept, rf_wen=0.
- Assert rst_n=0 while in WAIT -> all outputs 0 immediately; a late mem_rsp_valid after release causes no rf_wen; next instruction completes normally.
